// File: rtl/demux_1x2_buf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | demux_1x2_buf_pkg : shared widths and channel occupancy encoding      |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package demux_1x2_buf_pkg;

   localparam int C_DEF_WIDTH = 32;
   localparam int C_DEF_CNT_W = 16;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_e;

endpackage
`default_nettype wire

// File: rtl/demux_1x2_buf_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | demux_1x2_buf_if : producer stream plus two consumer streams          |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface demux_1x2_buf_if
   import demux_1x2_buf_pkg::*;
#(
   parameter int WIDTH = C_DEF_WIDTH,
   parameter int CNT_W = C_DEF_CNT_W
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_sel;
   logic             out1_valid;
   logic             out1_ready;
   logic [WIDTH-1:0] out1_data;
   logic             out2_valid;
   logic             out2_ready;
   logic [WIDTH-1:0] out2_data;
   logic [CNT_W-1:0] cnt1;
   logic [CNT_W-1:0] cnt2;

   modport master (
      output in_valid, in_data, in_sel, out1_ready, out2_ready,
      input  in_ready, out1_valid, out1_data, out2_valid, out2_data, cnt1, cnt2
   );

   modport slave (
      input  in_valid, in_data, in_sel, out1_ready, out2_ready,
      output in_ready, out1_valid, out1_data, out2_valid, out2_data, cnt1, cnt2
   );
endinterface
`default_nettype wire

// File: rtl/demux_1x2_buf_chan_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | demux_chan_fifo : 2-entry elastic buffer with handshake counter       |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module demux_chan_fifo
   import demux_1x2_buf_pkg::*;
#(
   parameter int WIDTH = C_DEF_WIDTH,
   parameter int CNT_W = C_DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             ready_i,
   output logic             valid_o,
   output logic             full_o,
   output logic [WIDTH-1:0] data_o,
   output logic [CNT_W-1:0] cnt_o
);
   occ_e             state_q, state_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             w_pop;

   assign w_pop = (state_q != OCC_EMPTY) && ready_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= OCC_EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         cnt_q   <= cnt_d;
      end
   end

   // Head is always the output word, so a pop from TWO shifts tail forward.
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      cnt_d   = w_pop ? cnt_q + CNT_W'(1) : cnt_q;
      unique case (state_q)
         OCC_EMPTY: begin
            if (push_i) begin
               state_d = OCC_ONE;
               head_d  = data_i;
            end
         end
         OCC_ONE: begin
            if (push_i && w_pop) begin
               head_d = data_i;
            end else if (push_i) begin
               state_d = OCC_TWO;
               tail_d  = data_i;
            end else if (w_pop) begin
               state_d = OCC_EMPTY;
            end
         end
         OCC_TWO: begin
            if (w_pop) begin
               state_d = OCC_ONE;
               head_d  = tail_q;
            end
         end
         default: state_d = OCC_EMPTY;
      endcase
   end

   always_comb begin
      valid_o = (state_q != OCC_EMPTY);
      full_o  = (state_q == OCC_TWO);
      data_o  = head_q;
      cnt_o   = cnt_q;
   end
endmodule
`default_nettype wire

// File: rtl/demux_1x2_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | demux_1x2_buf : steers one stream to two buffered consumer channels   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module demux_1x2_buf
   import demux_1x2_buf_pkg::*;
#(
   parameter int WIDTH = C_DEF_WIDTH,
   parameter int CNT_W = C_DEF_CNT_W
) (
   input  logic            clk,
   input  logic            rst,
   demux_1x2_buf_if.slave  bus
);
   logic w_full1;
   logic w_full2;
   logic w_accept;
   logic w_push1;
   logic w_push2;

   // Readiness comes only from registered fullness, never from consumer ready.
   assign bus.in_ready = bus.in_sel ? !w_full1 : !w_full2;
   assign w_accept     = bus.in_valid && bus.in_ready;
   assign w_push1      = w_accept &&  bus.in_sel;
   assign w_push2      = w_accept && !bus.in_sel;

   demux_chan_fifo #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_chan1 (
      .clk     (clk),
      .rst     (rst),
      .push_i  (w_push1),
      .data_i  (bus.in_data),
      .ready_i (bus.out1_ready),
      .valid_o (bus.out1_valid),
      .full_o  (w_full1),
      .data_o  (bus.out1_data),
      .cnt_o   (bus.cnt1)
   );

   demux_chan_fifo #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_chan2 (
      .clk     (clk),
      .rst     (rst),
      .push_i  (w_push2),
      .data_i  (bus.in_data),
      .ready_i (bus.out2_ready),
      .valid_o (bus.out2_valid),
      .full_o  (w_full2),
      .data_o  (bus.out2_data),
      .cnt_o   (bus.cnt2)
   );
endmodule
`default_nettype wire
